// File: rtl/io_map_pkg.sv
// Shared I/O map definitions: FSM states, default register addresses and decode result.
// Pure declarations, no logic; no latency or backpressure of its own.
package io_map_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [31:0] DEF_HEX_ADDR  = 32'hF000_0000;
  localparam logic [31:0] DEF_LEDR_ADDR = 32'hF000_0004;
  localparam logic [31:0] DEF_LEDG_ADDR = 32'hF000_0008;
  localparam logic [31:0] DEF_KEY_ADDR  = 32'hF000_0010;
  localparam logic [31:0] DEF_SW_ADDR   = 32'hF000_0014;

  typedef struct packed {
    logic hexWr;
    logic ledrWr;
    logic ledgWr;
    logic swRd;
    logic keyRd;
    logic bad;
  } decode_t;

endpackage

// File: rtl/io_addr_decoder.sv
// Address + direction to one-hot I/O access decode; purely combinational, zero latency.
// No flow control; also usable as an MMIO range check (dec.bad = not an I/O access).
module io_addr_decoder
  import io_map_pkg::*;
#(
  parameter int                        ADDR_BIT_WIDTH = 32,
  parameter logic [ADDR_BIT_WIDTH-1:0] HEX_ADDR       = DEF_HEX_ADDR,
  parameter logic [ADDR_BIT_WIDTH-1:0] LEDR_ADDR      = DEF_LEDR_ADDR,
  parameter logic [ADDR_BIT_WIDTH-1:0] LEDG_ADDR      = DEF_LEDG_ADDR,
  parameter logic [ADDR_BIT_WIDTH-1:0] KEY_ADDR       = DEF_KEY_ADDR,
  parameter logic [ADDR_BIT_WIDTH-1:0] SW_ADDR        = DEF_SW_ADDR
) (
  input  logic [ADDR_BIT_WIDTH-1:0] addr,
  input  logic                      we,
  output decode_t                   dec
);

  // Full-width compares: no aliasing, and a wrong direction is as bad as a wrong address.
  always_comb begin
    dec = '0;
    if (we) begin
      if (addr == HEX_ADDR)       dec.hexWr  = 1'b1;
      else if (addr == LEDR_ADDR) dec.ledrWr = 1'b1;
      else if (addr == LEDG_ADDR) dec.ledgWr = 1'b1;
      else                        dec.bad    = 1'b1;
    end else begin
      if (addr == SW_ADDR)        dec.swRd   = 1'b1;
      else if (addr == KEY_ADDR)  dec.keyRd  = 1'b1;
      else                        dec.bad    = 1'b1;
    end
  end

endmodule

// File: rtl/io_access_arbiter.sv
// Round-robin two-master access sequencer for the board I/O block; 3 cycles per access (IDLE, ACCESS, RESP).
// Requesters hold req until their one-cycle ack; only one transaction is in flight at a time.
module io_access_arbiter
  import io_map_pkg::*;
#(
  parameter int                        DATA_BIT_WIDTH = 32,
  parameter int                        ADDR_BIT_WIDTH = 32,
  parameter logic [ADDR_BIT_WIDTH-1:0] HEX_ADDR       = DEF_HEX_ADDR,
  parameter logic [ADDR_BIT_WIDTH-1:0] LEDR_ADDR      = DEF_LEDR_ADDR,
  parameter logic [ADDR_BIT_WIDTH-1:0] LEDG_ADDR      = DEF_LEDG_ADDR,
  parameter logic [ADDR_BIT_WIDTH-1:0] KEY_ADDR       = DEF_KEY_ADDR,
  parameter logic [ADDR_BIT_WIDTH-1:0] SW_ADDR        = DEF_SW_ADDR
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      req0,
  input  logic                      we0,
  input  logic [ADDR_BIT_WIDTH-1:0] addr0,
  input  logic [DATA_BIT_WIDTH-1:0] wdata0,
  input  logic                      req1,
  input  logic                      we1,
  input  logic [ADDR_BIT_WIDTH-1:0] addr1,
  input  logic [DATA_BIT_WIDTH-1:0] wdata1,
  output logic                      ack0,
  output logic                      ack1,
  output logic [DATA_BIT_WIDTH-1:0] rdata,
  output logic                      badAccess,
  output logic                      isHex,
  output logic                      isLedr,
  output logic                      isLedg,
  output logic                      isSwitches,
  output logic [DATA_BIT_WIDTH-1:0] dataIn,
  input  logic [DATA_BIT_WIDTH-1:0] ioOut
);

  logic [1:0]                rstSync;
  logic                      rstN;
  state_t                    state;
  state_t                    nextState;
  logic                      lastGrant;
  logic                      grant;
  logic                      winner;
  logic                      anyReq;
  logic                      latWe;
  logic [ADDR_BIT_WIDTH-1:0] latAddr;
  logic                      badFlag;
  decode_t                   dec;

  // Assert immediately, release two edges later so every flop leaves reset on the same edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) rstSync <= 2'b00;
    else         rstSync <= {rstSync[0], 1'b1};
  end
  assign rstN = rstSync[1];

  assign anyReq = req0 | req1;
  assign winner = (req0 & req1) ? ~lastGrant : req1;

  io_addr_decoder #(
    .ADDR_BIT_WIDTH(ADDR_BIT_WIDTH),
    .HEX_ADDR      (HEX_ADDR),
    .LEDR_ADDR     (LEDR_ADDR),
    .LEDG_ADDR     (LEDG_ADDR),
    .KEY_ADDR      (KEY_ADDR),
    .SW_ADDR       (SW_ADDR)
  ) u_dec (
    .addr(latAddr),
    .we  (latWe),
    .dec (dec)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState  = state;
    ack0       = 1'b0;
    ack1       = 1'b0;
    badAccess  = 1'b0;
    isHex      = 1'b0;
    isLedr     = 1'b0;
    isLedg     = 1'b0;
    isSwitches = 1'b0;
    case (state)
      IDLE: begin
        if (anyReq) nextState = ACCESS;
      end
      ACCESS: begin
        isHex      = dec.hexWr;
        isLedr     = dec.ledrWr;
        isLedg     = dec.ledgWr;
        isSwitches = dec.swRd;
        nextState  = RESP;
      end
      RESP: begin
        ack0      = ~grant;
        ack1      = grant;
        badAccess = badFlag;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // dataIn doubles as the write-data latch: it only changes when a write is granted.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      lastGrant <= 1'b1;
      grant     <= 1'b0;
      latWe     <= 1'b0;
      latAddr   <= '0;
      dataIn    <= '0;
      rdata     <= '0;
      badFlag   <= 1'b0;
    end else begin
      if (state == IDLE && anyReq) begin
        grant     <= winner;
        lastGrant <= winner;
        latWe     <= winner ? we1 : we0;
        latAddr   <= winner ? addr1 : addr0;
        if (winner ? we1 : we0) dataIn <= winner ? wdata1 : wdata0;
      end
      if (state == ACCESS) begin
        badFlag <= dec.bad;
        if (dec.swRd || dec.keyRd) rdata <= ioOut;
        else if (dec.bad)          rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_io_access_arbiter.sv
// Directed bench for io_access_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_io_access_arbiter;

  localparam logic [31:0] HEX  = 32'hF000_0000;
  localparam logic [31:0] LEDR = 32'hF000_0004;
  localparam logic [31:0] LEDG = 32'hF000_0008;
  localparam logic [31:0] KEY  = 32'hF000_0010;
  localparam logic [31:0] SW   = 32'hF000_0014;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic        ack0, ack1, badAccess, isHex, isLedr, isLedg, isSwitches;
  logic [31:0] rdata, dataIn;
  logic [31:0] ioOut = '0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  io_access_arbiter dut (
    .clk       (clk),
    .resetN    (resetN),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata     (rdata),
    .badAccess (badAccess),
    .isHex     (isHex),
    .isLedr    (isLedr),
    .isLedg    (isLedg),
    .isSwitches(isSwitches),
    .dataIn    (dataIn),
    .ioOut     (ioOut)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else             passes++;
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // {ack0, ack1, badAccess, isHex, isLedr, isLedg, isSwitches}
  function automatic logic [31:0] ctl();
    return {25'd0, ack0, ack1, badAccess, isHex, isLedr, isLedg, isSwitches};
  endfunction

  initial begin
    step(3);
    check("reset_ctl", ctl(), 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_datain", dataIn, 32'h0);
    resetN = 1'b1;
    step(3);

    // HEX write by requester 0
    req0 = 1'b1; we0 = 1'b1; addr0 = HEX; wdata0 = 32'h0040_7940;
    step();
    check("hex_access_ctl", ctl(), 32'b0001000);
    check("hex_datain", dataIn, 32'h0040_7940);
    step();
    check("hex_resp_ctl", ctl(), 32'b1000000);
    req0 = 1'b0;
    step();
    check("hex_idle_ctl", ctl(), 32'h0);
    check("hex_datain_hold", dataIn, 32'h0040_7940);

    // Switch read by requester 1
    ioOut = 32'h0000_02A5;
    req1 = 1'b1; we1 = 1'b0; addr1 = SW;
    step();
    check("sw_access_ctl", ctl(), 32'b0000001);
    step();
    check("sw_resp_ctl", ctl(), 32'b0100000);
    check("sw_rdata", rdata, 32'h0000_02A5);
    req1 = 1'b0;
    step();
    check("sw_idle_ctl", ctl(), 32'h0);
    check("sw_rdata_hold", rdata, 32'h0000_02A5);

    // Contention: both held, grants alternate 0,1,0,1 with acks 3 cycles apart
    req0 = 1'b1; we0 = 1'b1; addr0 = LEDR; wdata0 = 32'h0000_0011;
    req1 = 1'b1; we1 = 1'b1; addr1 = LEDG; wdata1 = 32'h0000_0022;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("rr%0d_access_ctl", k), ctl(), (k % 2 == 0) ? 32'b0000100 : 32'b0000010);
      check($sformatf("rr%0d_datain", k), dataIn, (k % 2 == 0) ? 32'h11 : 32'h22);
      step();
      check($sformatf("rr%0d_ack", k), ctl(), (k % 2 == 0) ? 32'b1000000 : 32'b0100000);
      if (k == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      step();
    end

    // Read of a write-only register, then write to an unmapped address
    req0 = 1'b1; we0 = 1'b0; addr0 = LEDR;
    step();
    check("badrd_access_ctl", ctl(), 32'h0);
    step();
    check("badrd_resp_ctl", ctl(), 32'b1010000);
    check("badrd_rdata", rdata, 32'h0);
    req0 = 1'b0;
    step();
    check("badrd_idle_ctl", ctl(), 32'h0);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'hF000_0020; wdata0 = 32'h0000_0055;
    step();
    check("badwr_access_ctl", ctl(), 32'h0);
    step();
    check("badwr_resp_ctl", ctl(), 32'b1010000);
    req0 = 1'b0;
    step();

    // Reset during ACCESS of a LEDG write; requester 0 wins so lastGrant would favour 1 without reset
    req0 = 1'b1; we0 = 1'b1; addr0 = LEDG; wdata0 = 32'h0000_0077;
    step();
    check("rst_pre_ctl", ctl(), 32'b0000010);
    #1 resetN = 1'b0;
    #1;
    check("rst_mid_ctl", ctl(), 32'h0);
    check("rst_mid_datain", dataIn, 32'h0);
    check("rst_mid_rdata", rdata, 32'h0);
    req0 = 1'b0;
    step();
    check("rst_noack_ctl", ctl(), 32'h0);
    resetN = 1'b1;
    step(3);

    // Tie after reset goes to requester 0 (KEY read); then req0 held across ack re-arms
    ioOut = 32'h0000_003C;
    req0 = 1'b1; we0 = 1'b0; addr0 = KEY;
    req1 = 1'b1; we1 = 1'b0; addr1 = SW;
    step();
    check("tie_access_ctl", ctl(), 32'h0);
    step();
    check("tie_resp_ctl", ctl(), 32'b1000000);
    check("tie_rdata", rdata, 32'h0000_003C);
    req1 = 1'b0;
    ioOut = 32'h0000_005A;
    step();
    check("hold_idle_ctl", ctl(), 32'h0);
    step();
    check("hold_access_ctl", ctl(), 32'h0);
    step();
    check("hold_resp_ctl", ctl(), 32'b1000000);
    check("hold_rdata", rdata, 32'h0000_005A);
    req0 = 1'b0;
    step(2);
    check("final_idle_ctl", ctl(), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
